micro_sequencer: RTL and testbench

- Consumer of the C/N/Z/P flag outputs: the microprogram sequencer for the PDUA core.
- Holds the micro-PC (uaddr) that addresses the asynchronous microcode ROM.
- Each cycle it executes the sequencing field of the current microinstruction: next, conditional jump/call, return, opcode dispatch, fetch or halt.
- Conditions are evaluated against the registered flags.

---
 rtl/micro_sequencer_pkg.sv | 32 +++
 rtl/micro_sequencer_cond_mux.sv | 30 +++
 rtl/micro_sequencer.sv | 150 +++++++++++++++
 tb/tb_micro_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/micro_sequencer_pkg.sv
// Shared encodings for the PDUA microprogram sequencer: sequencing ops,
// condition selects and controller states.
package micro_sequencer_pkg;

   // Sequencing field of a microinstruction
   localparam logic [2:0] USEQ_NEXT     = 3'd0;
   localparam logic [2:0] USEQ_JUMP     = 3'd1;
   localparam logic [2:0] USEQ_DISPATCH = 3'd2;
   localparam logic [2:0] USEQ_FETCH    = 3'd3;
   localparam logic [2:0] USEQ_CALL     = 3'd4;
   localparam logic [2:0] USEQ_RET      = 3'd5;
   localparam logic [2:0] USEQ_HALT     = 3'd6;
   localparam logic [2:0] USEQ_RSVD     = 3'd7;

   // Condition select field
   localparam logic [2:0] COND_ALWAYS = 3'd0;
   localparam logic [2:0] COND_C      = 3'd1;
   localparam logic [2:0] COND_NC     = 3'd2;
   localparam logic [2:0] COND_Z      = 3'd3;
   localparam logic [2:0] COND_NZ     = 3'd4;
   localparam logic [2:0] COND_N      = 3'd5;
   localparam logic [2:0] COND_NN     = 3'd6;
   localparam logic [2:0] COND_P      = 3'd7;

   // Controller states; ST_STALL is only reachable with the hazard-stall build
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_STALL = 2'd2
   } state_t;

endpackage

// File: rtl/micro_sequencer_cond_mux.sv
// Branch condition multiplexer: selects one flag (or its inverse) according
// to the microinstruction's condition field.
module micro_sequencer_cond_mux
   import micro_sequencer_pkg::*;
(
   input  logic [2:0] cond_sel_i,
   input  logic       c_i,
   input  logic       n_i,
   input  logic       z_i,
   input  logic       p_i,
   output logic       cond_o
);

   // Pure decode of the condition field against the registered flags
   always_comb begin
      cond_o = 1'b1;
      case (cond_sel_i)
         COND_ALWAYS: cond_o = 1'b1;
         COND_C:      cond_o = c_i;
         COND_NC:     cond_o = ~c_i;
         COND_Z:      cond_o = z_i;
         COND_NZ:     cond_o = ~z_i;
         COND_N:      cond_o = n_i;
         COND_NN:     cond_o = ~n_i;
         COND_P:      cond_o = p_i;
         default:     cond_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer for the PDUA core. Holds the micro-PC that addresses
// the asynchronous microcode ROM and executes one sequencing op per cycle.
// Optional build macro USEQ_FLAG_HAZARD_STALL_EN: a conditional JUMP/CALL
// issued together with a flag write waits one cycle (STALL) so the branch
// sees the updated flags.
module micro_sequencer
   import micro_sequencer_pkg::*;
#(
   parameter int                     UADDR_WIDTH  = 8,
   parameter int                     OPCODE_WIDTH = 5,
   parameter logic [UADDR_WIDTH-1:0] FETCH_ADDR   = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    hold,
   input  logic [2:0]              useq_op,
   input  logic [2:0]              cond_sel,
   input  logic [UADDR_WIDTH-1:0]  jump_addr,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    enaf,
   input  logic                    C,
   input  logic                    N,
   input  logic                    Z,
   input  logic                    P,
   output logic [UADDR_WIDTH-1:0]  uaddr,
   output logic                    taken,
   output logic                    halted,
   output logic                    stall
);

   state_t                  state_q;
   logic [UADDR_WIDTH-1:0]  uaddr_q, uaddr_d;
   logic [UADDR_WIDTH-1:0]  ret_q, ret_d;
   logic                    taken_q, taken_d;
   logic                    halted_q, stall_q;
   logic [UADDR_WIDTH-1:0]  uaddr_inc;
   logic                    cond;
   logic                    halt_req;
   logic                    hazard;

   micro_sequencer_cond_mux u_cond_mux (
      .cond_sel_i (cond_sel),
      .c_i        (C),
      .n_i        (N),
      .z_i        (Z),
      .p_i        (P),
      .cond_o     (cond)
   );

   assign uaddr_inc = uaddr_q + UADDR_WIDTH'(1);

`ifdef USEQ_FLAG_HAZARD_STALL_EN
   // A conditional branch in the same microinstruction as a flag write would
   // otherwise test stale flags; flag it so RUN can detour through STALL.
   assign hazard = ((useq_op == USEQ_JUMP) || (useq_op == USEQ_CALL)) &&
                   (cond_sel != COND_ALWAYS) && enaf;
`else
   // Base build: branches always use the flags present at the edge.
   logic unused_enaf;
   assign unused_enaf = enaf;
   assign hazard      = 1'b0;
`endif

   // Next micro-PC, return address and taken flag for the presented op
   always_comb begin
      uaddr_d  = uaddr_inc;
      ret_d    = ret_q;
      taken_d  = taken_q;
      halt_req = 1'b0;
      case (useq_op)
         USEQ_NEXT: uaddr_d = uaddr_inc;
         USEQ_JUMP: begin
            taken_d = cond;
            uaddr_d = cond ? jump_addr : uaddr_inc;
         end
         USEQ_DISPATCH: uaddr_d = UADDR_WIDTH'(opcode) << (UADDR_WIDTH - OPCODE_WIDTH);
         USEQ_FETCH:    uaddr_d = FETCH_ADDR;
         USEQ_CALL: begin
            taken_d = cond;
            if (cond) begin
               ret_d   = uaddr_inc;
               uaddr_d = jump_addr;
            end
         end
         USEQ_RET: uaddr_d = ret_q;
         USEQ_HALT: begin
            uaddr_d  = uaddr_q;
            halt_req = 1'b1;
         end
         USEQ_RSVD: uaddr_d = uaddr_inc;
         default:   uaddr_d = uaddr_inc;
      endcase
   end

   // Controller FSM: reset, hold freeze, RUN/HALT/STALL sequencing
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         uaddr_q  <= FETCH_ADDR;
         ret_q    <= '0;
         taken_q  <= 1'b0;
         halted_q <= 1'b0;
         stall_q  <= 1'b0;
      end else if (!hold) begin
         case (state_q)
            ST_RUN: begin
               if (halt_req) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else if (hazard) begin
                  state_q <= ST_STALL;
                  stall_q <= 1'b1;
               end else begin
                  uaddr_q <= uaddr_d;
                  ret_q   <= ret_d;
                  taken_q <= taken_d;
               end
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
`ifdef USEQ_FLAG_HAZARD_STALL_EN
            ST_STALL: begin
               // Re-presented op runs with updated flags; enaf no longer matters
               stall_q <= 1'b0;
               if (halt_req) begin
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= ST_RUN;
                  uaddr_q <= uaddr_d;
                  ret_q   <= ret_d;
                  taken_q <= taken_d;
               end
            end
`endif
            default: begin
               state_q <= ST_RUN;
               stall_q <= 1'b0;
            end
         endcase
      end
   end

   assign uaddr  = uaddr_q;
   assign taken  = taken_q;
   assign halted = halted_q;
   assign stall  = stall_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer. The driver applies one microinstruction
// per cycle on the falling edge and queues the hand-computed register state
// expected after the following rising edge; a monitor pops and compares.
module tb_micro_sequencer;
   import micro_sequencer_pkg::*;

   localparam int W = 11; // {uaddr[7:0], taken, halted, stall}

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst, hold, enaf, C, N, Z, P;
   logic [2:0] useq_op, cond_sel;
   logic [7:0] jump_addr;
   logic [4:0] opcode;
   logic [7:0] uaddr;
   logic       taken, halted, stall;

   always #5 clk = ~clk;

   micro_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .hold      (hold),
      .useq_op   (useq_op),
      .cond_sel  (cond_sel),
      .jump_addr (jump_addr),
      .opcode    (opcode),
      .enaf      (enaf),
      .C         (C),
      .N         (N),
      .Z         (Z),
      .P         (P),
      .uaddr     (uaddr),
      .taken     (taken),
      .halted    (halted),
      .stall     (stall)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks = 0;
   int           errors = 0;

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         logic [W-1:0] e;
         logic [W-1:0] g;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         g  = {uaddr, taken, halted, stall};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL %s: got uaddr=%h taken=%b halted=%b stall=%b, expected uaddr=%h taken=%b halted=%b stall=%b",
                     nm, g[10:3], g[2], g[1], g[0], e[10:3], e[2], e[1], e[0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_op(input logic [2:0] op, input logic [2:0] sel, input logic [7:0] ja);
      useq_op   = op;
      cond_sel  = sel;
      jump_addr = ja;
   endtask

   // Inputs are already applied at this falling edge; queue the state expected
   // after the next rising edge and move on to the next falling edge.
   task automatic step(input logic [7:0] ea, input logic et, input logic eh,
                       input logic es, input string nm);
      exp_q.push_back({ea, et, eh, es});
      name_q.push_back(nm);
      @(negedge clk);
      rst  = 1'b0;
      hold = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; hold = 1'b0; enaf = 1'b0;
      C = 1'b0; N = 1'b0; Z = 1'b0; P = 1'b0;
      opcode = 5'd0;
      set_op(USEQ_NEXT, COND_ALWAYS, 8'h00);
      @(negedge clk);

      // reset then sequential stepping
      rst = 1'b1; set_op(USEQ_NEXT, COND_ALWAYS, 8'h00);
      step(8'h00, 1'b0, 1'b0, 1'b0, "reset");
      for (int i = 1; i <= 3; i++) begin
         set_op(USEQ_NEXT, COND_ALWAYS, 8'h00);
         step(8'(i), 1'b0, 1'b0, 1'b0, "next");
      end

      // wrap-around
      set_op(USEQ_JUMP, COND_ALWAYS, 8'hFF); step(8'hFF, 1'b1, 1'b0, 1'b0, "jump_always_ff");
      set_op(USEQ_NEXT, COND_ALWAYS, 8'h00); step(8'h00, 1'b1, 1'b0, 1'b0, "next_wrap");

      // JUMP on Z true / false
      Z = 1'b1; set_op(USEQ_JUMP, COND_Z, 8'h40); step(8'h40, 1'b1, 1'b0, 1'b0, "jump_z_true");
      set_op(USEQ_JUMP, COND_ALWAYS, 8'h10);      step(8'h10, 1'b1, 1'b0, 1'b0, "jump_to_10");
      Z = 1'b0; set_op(USEQ_JUMP, COND_Z, 8'h40); step(8'h11, 1'b0, 1'b0, 1'b0, "jump_z_false");

      // DISPATCH and FETCH
      opcode = 5'b00011;
      set_op(USEQ_DISPATCH, COND_ALWAYS, 8'h00); step(8'h18, 1'b0, 1'b0, 1'b0, "dispatch_3");
      set_op(USEQ_FETCH, COND_ALWAYS, 8'h77);    step(8'h00, 1'b0, 1'b0, 1'b0, "fetch");

      // CALL / RET with single-level return register
      set_op(USEQ_JUMP, COND_ALWAYS, 8'h20); step(8'h20, 1'b1, 1'b0, 1'b0, "jump_to_20");
      set_op(USEQ_CALL, COND_ALWAYS, 8'h80); step(8'h80, 1'b1, 1'b0, 1'b0, "call_80");
      set_op(USEQ_NEXT, COND_ALWAYS, 8'h00); step(8'h81, 1'b1, 1'b0, 1'b0, "next_in_sub");
      C = 1'b0; set_op(USEQ_CALL, COND_C, 8'h90); step(8'h82, 1'b0, 1'b0, 1'b0, "call_false");
      set_op(USEQ_RET, COND_ALWAYS, 8'h00);  step(8'h21, 1'b0, 1'b0, 1'b0, "ret");
      set_op(USEQ_RET, COND_ALWAYS, 8'h00);  step(8'h21, 1'b0, 1'b0, 1'b0, "ret_again");

      // remaining condition selects
      C = 1'b0; set_op(USEQ_JUMP, COND_NC, 8'h50); step(8'h50, 1'b1, 1'b0, 1'b0, "jump_nc");
      N = 1'b1; set_op(USEQ_JUMP, COND_N, 8'h60);  step(8'h60, 1'b1, 1'b0, 1'b0, "jump_n");
      set_op(USEQ_JUMP, COND_NN, 8'hA0);           step(8'h61, 1'b0, 1'b0, 1'b0, "jump_nn_false");
      P = 1'b1; set_op(USEQ_JUMP, COND_P, 8'h70);  step(8'h70, 1'b1, 1'b0, 1'b0, "jump_p");
      Z = 1'b0; set_op(USEQ_JUMP, COND_NZ, 8'h30); step(8'h30, 1'b1, 1'b0, 1'b0, "jump_nz");
      set_op(USEQ_RSVD, COND_ALWAYS, 8'hEE);       step(8'h31, 1'b1, 1'b0, 1'b0, "reserved_as_next");
      set_op(USEQ_NEXT, COND_ALWAYS, 8'h00);       step(8'h32, 1'b1, 1'b0, 1'b0, "next_32");
      set_op(USEQ_NEXT, COND_ALWAYS, 8'h00);       step(8'h33, 1'b1, 1'b0, 1'b0, "next_33");

      // hold freezes everything
      hold = 1'b1; set_op(USEQ_JUMP, COND_NN, 8'h99); step(8'h33, 1'b1, 1'b0, 1'b0, "hold_jump");

      // HALT holds for 10 cycles regardless of op
      set_op(USEQ_HALT, COND_ALWAYS, 8'h00); step(8'h33, 1'b1, 1'b1, 1'b0, "halt_enter");
      for (int i = 0; i < 10; i++) begin
         set_op((i % 2 == 0) ? USEQ_JUMP : USEQ_NEXT, COND_ALWAYS, 8'hAA);
         step(8'h33, 1'b1, 1'b1, 1'b0, "halt_stay");
      end
      rst = 1'b1; set_op(USEQ_NEXT, COND_ALWAYS, 8'h00); step(8'h00, 1'b0, 1'b0, 1'b0, "reset_from_halt");

      // flag-write hazard on a conditional branch
      set_op(USEQ_JUMP, COND_ALWAYS, 8'h10); step(8'h10, 1'b1, 1'b0, 1'b0, "jump_to_10b");
      C = 1'b0; enaf = 1'b1; set_op(USEQ_JUMP, COND_C, 8'h44);
`ifdef USEQ_FLAG_HAZARD_STALL_EN
      step(8'h10, 1'b1, 1'b0, 1'b1, "hazard_stall");
`else
      step(8'h11, 1'b0, 1'b0, 1'b0, "hazard_old_flags");
`endif
      C = 1'b1; set_op(USEQ_JUMP, COND_C, 8'h44); step(8'h44, 1'b1, 1'b0, 1'b0, "hazard_resolve");
      set_op(USEQ_JUMP, COND_ALWAYS, 8'h55);       step(8'h55, 1'b1, 1'b0, 1'b0, "enaf_always_no_stall");
      Z = 1'b1; set_op(USEQ_JUMP, COND_Z, 8'h66);
`ifdef USEQ_FLAG_HAZARD_STALL_EN
      step(8'h55, 1'b1, 1'b0, 1'b1, "hazard_stall_z");
`else
      step(8'h66, 1'b1, 1'b0, 1'b0, "jump_z_enaf");
`endif
      enaf = 1'b0; rst = 1'b1; set_op(USEQ_NEXT, COND_ALWAYS, 8'h00);
      step(8'h00, 1'b0, 1'b0, 1'b0, "reset_final");

      // drain the scoreboard with a bounded wait
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
